// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud divider helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per sample tick; every line bit lasts sampling_rate ticks.
    function automatic int calc_div(input int clock_freq, input int baud_rate, input int sampling_rate);
        return clock_freq / (baud_rate * sampling_rate);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int SAMPLING_RATE = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int DIV    = calc_div(CLOCK_FREQ, BAUD_RATE, SAMPLING_RATE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = (SAMPLING_RATE > 1) ? $clog2(SAMPLING_RATE) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLING_RATE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t       state;
    logic [DIV_W-1:0]  div_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              bit_end;
    logic              fifo_pop;
    logic [7:0]        fifo_data;
    logic              fifo_full;
    logic              fifo_empty;

    assign ready    = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign bit_end  = (div_cnt == DIV_LAST) && (samp_cnt == SAMP_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (valid),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // tx is registered from the current state, so the line trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            samp_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                if (bit_end) begin
                    div_cnt  <= '0;
                    samp_cnt <= '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt  <= '0;
                    samp_cnt <= samp_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_data;
                        div_cnt  <= '0;
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (bit_end) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [2:0] count;

    int total;
    int bad;

    uart_tx_fifo #(
        .CLOCK_FREQ    (32),
        .BAUD_RATE     (1),
        .SAMPLING_RATE (16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered off cycles after the first tx-low sample E; leaves at E+319 (tx_done high).
    task automatic check_frame(input string tag, input logic [7:0] b, input int off);
        adv(16 - off);
        chk({tag, "_start"}, tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            adv(32);
            chk($sformatf("%s_bit%0d", tag, i), tx, b[i]);
        end
        adv(32);
        chk({tag, "_stop"}, tx, 1'b1);
        adv(14);
        chk({tag, "_done_early"}, tx_done, 1'b0);
        adv(1);
        chk({tag, "_done"}, tx_done, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    // From the end of a frame: pop on the next edge, tx low on the one after.
    task automatic next_frame(input string tag, input logic [2:0] cnt_after_pop);
        adv(1);
        chk({tag, "_count_pop"}, count, cnt_after_pop);
        adv(1);
        chk({tag, "_gap_start"}, tx, 1'b0);
    endtask

    initial begin
        int tx_bad;
        int done_seen;
        clk     = 1'b0;
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        total   = 0;
        bad     = 0;

        adv(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b0;

        // Idle line
        tx_bad = 0;
        done_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            adv(1);
            if (tx !== 1'b1) tx_bad++;
            if (tx_done !== 1'b0) done_seen++;
        end
        chk("idle_tx", tx_bad, 0);
        chk("idle_done", done_seen, 0);

        // Single byte 0xA5
        valid = 1'b1;
        data_in = 8'hA5;
        adv(1);
        chk("a5_count_push", count, 3'd1);
        valid = 1'b0;
        adv(1);
        chk("a5_busy_pop", busy, 1'b1);
        chk("a5_tx_pop", tx, 1'b1);
        chk("a5_count_pop", count, 3'd0);
        adv(1);
        chk("a5_tx_low", tx, 1'b0);
        check_frame("a5", 8'hA5, 0);
        adv(1);
        chk("a5_done_pulse", tx_done, 1'b0);
        chk("a5_busy_after", busy, 1'b0);

        // Back-to-back 0x00, 0xFF, 0x55
        valid = 1'b1;
        data_in = 8'h00;
        adv(1);
        chk("b2b_count0", count, 3'd1);
        data_in = 8'hFF;
        adv(1);
        chk("b2b_count1", count, 3'd1);
        data_in = 8'h55;
        adv(1);
        chk("b2b_count2", count, 3'd2);
        valid = 1'b0;
        chk("b2b_tx_low", tx, 1'b0);
        check_frame("b2b_00", 8'h00, 0);
        next_frame("b2b_ff", 3'd1);
        check_frame("b2b_ff", 8'hFF, 0);
        next_frame("b2b_55", 3'd0);
        check_frame("b2b_55", 8'h55, 0);

        // Fill the FIFO during frame 0xF0, fifth byte dropped
        valid = 1'b1;
        data_in = 8'hF0;
        adv(1);
        valid = 1'b0;
        adv(1);
        adv(1);
        chk("full_tx_low", tx, 1'b0);
        valid = 1'b1;
        data_in = 8'h11;
        adv(1);
        chk("full_count1", count, 3'd1);
        data_in = 8'h22;
        adv(1);
        chk("full_count2", count, 3'd2);
        data_in = 8'h33;
        adv(1);
        chk("full_ready3", ready, 1'b1);
        data_in = 8'h44;
        adv(1);
        chk("full_count4", count, 3'd4);
        chk("full_ready4", ready, 1'b0);
        data_in = 8'h55;
        adv(1);
        chk("full_drop_count", count, 3'd4);
        chk("full_drop_ready", ready, 1'b0);
        valid = 1'b0;
        check_frame("f0", 8'hF0, 5);

        // Pop while full with valid held
        valid = 1'b1;
        data_in = 8'h66;
        chk("simul_count_pre", count, 3'd4);
        chk("simul_ready_pre", ready, 1'b0);
        adv(1);
        chk("simul_count_pop", count, 3'd3);
        chk("simul_ready_pop", ready, 1'b1);
        adv(1);
        chk("simul_count_acc", count, 3'd4);
        chk("simul_ready_acc", ready, 1'b0);
        chk("simul_tx_low", tx, 1'b0);
        valid = 1'b0;
        check_frame("q11", 8'h11, 0);
        next_frame("q22", 3'd3);
        check_frame("q22", 8'h22, 0);
        next_frame("q33", 3'd2);
        check_frame("q33", 8'h33, 0);
        next_frame("q44", 3'd1);
        check_frame("q44", 8'h44, 0);
        next_frame("q66", 3'd0);
        check_frame("q66", 8'h66, 0);
        tx_bad = 0;
        for (int i = 0; i < 400; i++) begin
            adv(1);
            if (tx !== 1'b1) tx_bad++;
        end
        chk("drained_tx", tx_bad, 0);

        // Reset in bit 3 of 0x3C with two bytes queued
        valid = 1'b1;
        data_in = 8'h3C;
        adv(1);
        data_in = 8'hAA;
        adv(1);
        data_in = 8'hBB;
        adv(1);
        valid = 1'b0;
        chk("rstf_count", count, 3'd2);
        chk("rstf_tx_low", tx, 1'b0);
        adv(142);
        chk("rstf_bit3", tx, 1'b1);
        chk("rstf_busy", busy, 1'b1);
        rst = 1'b1;
        valid = 1'b1;
        data_in = 8'h77;
        adv(1);
        chk("rstf_tx", tx, 1'b1);
        chk("rstf_busy_clr", busy, 1'b0);
        chk("rstf_count_clr", count, 3'd0);
        chk("rstf_ready", ready, 1'b1);
        chk("rstf_done", tx_done, 1'b0);
        rst = 1'b0;
        valid = 1'b0;
        tx_bad = 0;
        done_seen = 0;
        for (int i = 0; i < 700; i++) begin
            adv(1);
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) tx_bad++;
            if (tx_done !== 1'b0) done_seen++;
        end
        chk("rstf_quiet", tx_bad, 0);
        chk("rstf_no_done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
